// File: rtl/level_sequencer_pkg.sv
// level_sequencer_pkg
//   Shared types and default level constants for the level sequencer and the
//   per-round game controller it sits beside.
//   Contents:
//     game_state_t  - round state reported by the game controller
//     seq_state_t   - level sequencer FSM state
//     DEF_*         - default campaign tuning values
package level_sequencer_pkg;

  typedef enum logic [1:0] {
    WAITING   = 2'd0,
    COUNTDOWN = 2'd1,
    SUCCESS   = 2'd2,
    FAILURE   = 2'd3
  } game_state_t;

  typedef enum logic [1:0] {
    READY   = 2'd0,
    PLAYING = 2'd1,
    HOLD    = 2'd2
  } seq_state_t;

  localparam int unsigned DEF_BASE_TIME    = 1500;
  localparam int unsigned DEF_TIME_STEP    = 100;
  localparam int unsigned DEF_MIN_TIME     = 300;
  localparam int unsigned DEF_BASE_BUTTONS = 6;
  localparam int unsigned DEF_MAX_BUTTONS  = 16;
  localparam int unsigned DEF_MAX_LEVEL    = 7;
  localparam int unsigned DEF_HOLD_TICKS   = 200;

endpackage

// File: rtl/level_sequencer_if.sv
// level_sequencer_if
//   Bundles the sequencer's player/game-controller side signals.
//   Optional: LEVEL_SEQUENCER_BEST_LEVEL_EN adds best_level.
//   Signals:
//     start_req     player start button level (active high)
//     game_state    round state from the game controller
//     start_pulse   one-cycle start strobe to the game controller
//     initial_time  round time configuration (game ticks)
//     button_count  round button count configuration
//     level_num     current level index
//     campaign_done sticky "last level cleared" flag
//     busy          high while a round is playing or its result is held
//     best_level    highest level reached since reset (optional)
//   Modports:
//     slave  - the sequencer itself
//     master - the environment (player input + game controller)
interface level_sequencer_if;
  import level_sequencer_pkg::*;

  logic        start_req;
  game_state_t game_state;
  logic        start_pulse;
  logic [10:0] initial_time;
  logic [5:0]  button_count;
  logic [2:0]  level_num;
  logic        campaign_done;
  logic        busy;
`ifdef LEVEL_SEQUENCER_BEST_LEVEL_EN
  logic [2:0]  best_level;

  modport slave (
    input  start_req, game_state,
    output start_pulse, initial_time, button_count, level_num,
           campaign_done, busy, best_level
  );

  modport master (
    output start_req, game_state,
    input  start_pulse, initial_time, button_count, level_num,
           campaign_done, busy, best_level
  );
`else
  modport slave (
    input  start_req, game_state,
    output start_pulse, initial_time, button_count, level_num,
           campaign_done, busy
  );

  modport master (
    output start_req, game_state,
    input  start_pulse, initial_time, button_count, level_num,
           campaign_done, busy
  );
`endif

endinterface

// File: rtl/level_sequencer_edge_detect.sv
// level_sequencer_edge_detect
//   Registered rising-edge detector: rise_o is high while sig_i is high and
//   was low on the previous clock.
//   Ports:
//     clk    clock
//     rst    synchronous active-high reset (history cleared to 0)
//     sig_i  level to watch
//     rise_o rising-edge indication (combinational from sig_i and history)
module level_sequencer_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/level_sequencer.sv
// level_sequencer
//   Sequences rounds of the game controller across a multi-level campaign:
//   arms a round on the player's start press, watches the round result and
//   reprograms time limit / button count, then holds the result for
//   HOLD_TICKS cycles before another round may start.
//   Optional: LEVEL_SEQUENCER_BEST_LEVEL_EN adds a best_level output that
//   remembers the highest level reached since reset.
//   Ports:
//     clk  game tick clock (only clock)
//     rst  synchronous active-high reset
//     bus  level_sequencer_if.slave (start_req, game_state in;
//          start_pulse, initial_time, button_count, level_num,
//          campaign_done, busy [, best_level] out)
//
//   state   | meaning
//   --------+------------------------------------------------------
//   READY   | idle, waiting for a fresh start press while WAITING
//   PLAYING | round running, config frozen, watching for a result
//   HOLD    | result shown, down-counter running to terminal count
module level_sequencer
  import level_sequencer_pkg::*;
#(
  parameter int unsigned BASE_TIME    = DEF_BASE_TIME,
  parameter int unsigned TIME_STEP    = DEF_TIME_STEP,
  parameter int unsigned MIN_TIME     = DEF_MIN_TIME,
  parameter int unsigned BASE_BUTTONS = DEF_BASE_BUTTONS,
  parameter int unsigned MAX_BUTTONS  = DEF_MAX_BUTTONS,
  parameter int unsigned MAX_LEVEL    = DEF_MAX_LEVEL,
  parameter int unsigned HOLD_TICKS   = DEF_HOLD_TICKS
) (
  input logic              clk,
  input logic              rst,
  level_sequencer_if.slave bus
);

  localparam int unsigned CNT_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_TICKS - 1);
  localparam logic [10:0] BASE_T  = 11'(BASE_TIME);
  localparam logic [10:0] MIN_T   = 11'(MIN_TIME);
  localparam logic [5:0]  BASE_B  = 6'(BASE_BUTTONS);
  localparam logic [5:0]  MAX_B   = 6'(MAX_BUTTONS);
  localparam logic [2:0]  MAX_LVL = 3'(MAX_LEVEL);

  logic start_rise, win_edge, lose_edge;

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [2:0]       level_q, level_d;
  logic [10:0]      time_q, time_d;
  logic [5:0]       buttons_q, buttons_d;
  logic             done_q, done_d;
  logic             pulse_q, pulse_d;
  logic             busy_q, busy_d;

  logic signed [11:0] time_dec;
  logic [10:0]        time_lvl_up;
  logic [5:0]         buttons_lvl_up;

  level_sequencer_edge_detect u_start_edge (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (bus.start_req),
    .rise_o (start_rise)
  );

  level_sequencer_edge_detect u_win_edge (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (bus.game_state == SUCCESS),
    .rise_o (win_edge)
  );

  level_sequencer_edge_detect u_lose_edge (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (bus.game_state == FAILURE),
    .rise_o (lose_edge)
  );

  // One extra sign bit so a step larger than the current time goes negative
  // and hits the floor instead of wrapping.
  assign time_dec       = $signed({1'b0, time_q}) - $signed(12'(TIME_STEP));
  assign time_lvl_up    = (time_dec < $signed(12'(MIN_TIME))) ? MIN_T : time_dec[10:0];
  assign buttons_lvl_up = (buttons_q >= MAX_B) ? MAX_B : buttons_q + 6'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= READY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      READY:   if (start_rise && bus.game_state == WAITING) state_d = PLAYING;
      PLAYING: if (win_edge || lose_edge) state_d = HOLD;
      HOLD:    if (hold_cnt_q == '0) state_d = READY;
      default: state_d = READY;
    endcase
  end

  always_comb begin
    pulse_d    = 1'b0;
    busy_d     = (state_d != READY);
    hold_cnt_d = hold_cnt_q;
    level_d    = level_q;
    time_d     = time_q;
    buttons_d  = buttons_q;
    done_d     = done_q;
    case (state_q)
      READY: begin
        if (state_d == PLAYING) pulse_d = 1'b1;
      end
      PLAYING: begin
        if (win_edge) begin
          hold_cnt_d = HOLD_LOAD;
          if (level_q < MAX_LVL) begin
            level_d   = level_q + 3'd1;
            time_d    = time_lvl_up;
            buttons_d = buttons_lvl_up;
          end else begin
            done_d = 1'b1;
          end
        end else if (lose_edge) begin
          hold_cnt_d = HOLD_LOAD;
          level_d    = 3'd0;
          time_d     = BASE_T;
          buttons_d  = BASE_B;
          done_d     = 1'b0;
        end
      end
      HOLD: begin
        if (hold_cnt_q != '0) hold_cnt_d = hold_cnt_q - CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_q <= '0;
      level_q    <= 3'd0;
      time_q     <= BASE_T;
      buttons_q  <= BASE_B;
      done_q     <= 1'b0;
      pulse_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      level_q    <= level_d;
      time_q     <= time_d;
      buttons_q  <= buttons_d;
      done_q     <= done_d;
      pulse_q    <= pulse_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.start_pulse   = pulse_q;
  assign bus.initial_time  = time_q;
  assign bus.button_count  = buttons_q;
  assign bus.level_num     = level_q;
  assign bus.campaign_done = done_q;
  assign bus.busy          = busy_q;

`ifdef LEVEL_SEQUENCER_BEST_LEVEL_EN
  logic [2:0] best_q, best_d, best_cand;

  assign best_cand = (level_q < MAX_LVL) ? level_q + 3'd1 : MAX_LVL;

  always_comb begin
    best_d = best_q;
    if (state_q == PLAYING && win_edge && best_cand > best_q) best_d = best_cand;
  end

  // Deliberately untouched by a lost round; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      best_q <= 3'd0;
    end else begin
      best_q <= best_d;
    end
  end

  assign bus.best_level = best_q;
`endif

endmodule
